// File: rtl/exec_pkg.sv
// exec_pkg: shared constants for the exec_core execute slice.
// ALU operation codes, major opcodes and the funct3 -> ALU op mapping.
package exec_pkg;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;
    localparam logic [3:0] ALU_NOP    = 4'b1111;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // is_reg distinguishes OP (SUB allowed) from OP-IMM (funct3 000 is always ADD)
    function automatic logic [3:0] alu_from_funct(
        input logic [2:0] f3,
        input logic       f7_5,
        input logic       is_reg
    );
        logic [3:0] op;
        unique case (f3)
            3'b000:  op = (is_reg && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exec_if.sv
// exec_if: instruction fields and operands in, decode and ALU results out.
// master = fetch/decode side, slave = exec_core.
interface exec_if;

    logic [6:0] cu_op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] result;
    logic       carry_out;

    modport master (
        output cu_op, funct3, funct7_5, A, B,
        input  alu_op, mem_read, mem_write, result, carry_out
    );

    modport slave (
        input  cu_op, funct3, funct7_5, A, B,
        output alu_op, mem_read, mem_write, result, carry_out
    );

endinterface

// File: rtl/exec_tickgen.sv
// exec_tickgen: LSI divider (clk cycles) cascaded into a WDT divider (lsi ticks).
// Ticks are decoded from the counters so they drop the moment enables or reset do.
module exec_tickgen #(
    parameter int LSI_DIV = 32,
    parameter int WDT_DIV = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic lsi_en_i,
    output logic lsi_tick_o,
    output logic wdt_tick_o
);

    localparam int LW = $clog2(LSI_DIV);
    localparam int WW = $clog2(WDT_DIV);
    localparam logic [LW-1:0] LSI_MAX = LW'(LSI_DIV - 1);
    localparam logic [WW-1:0] WDT_MAX = WW'(WDT_DIV - 1);

    logic [LW-1:0] lsi_cnt_q, lsi_cnt_d;
    logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;

    // next counts and wrap pulses; everything holds while en_i is low
    always_comb begin
        lsi_cnt_d  = lsi_cnt_q;
        wdt_cnt_d  = wdt_cnt_q;
        lsi_tick_o = 1'b0;
        wdt_tick_o = 1'b0;
        if (en_i) begin
            if (!lsi_en_i) begin
                lsi_cnt_d = '0;
            end else if (lsi_cnt_q == LSI_MAX) begin
                lsi_cnt_d  = '0;
                lsi_tick_o = 1'b1;
            end else begin
                lsi_cnt_d = lsi_cnt_q + LW'(1);
            end
            if (lsi_tick_o) begin
                if (wdt_cnt_q == WDT_MAX) begin
                    wdt_cnt_d  = '0;
                    wdt_tick_o = 1'b1;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + WW'(1);
                end
            end
        end
    end

    // counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lsi_cnt_q <= '0;
            wdt_cnt_q <= '0;
        end else begin
            lsi_cnt_q <= lsi_cnt_d;
            wdt_cnt_q <= wdt_cnt_d;
        end
    end

endmodule

// File: rtl/exec_core.sv
// exec_core: opcode decoder, registered 8-bit ALU and LSI/WDT tick generator.
// Define ALU_SHIFT_EN to build the shifter; otherwise shift codes hold like NOP.
module exec_core
    import exec_pkg::*;
#(
    parameter int LSI_DIV = 32,
    parameter int WDT_DIV = 128
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  clk_enable,
    input  logic  lsi_enable,
    exec_if.slave bus,
    output logic  lsi_tick,
    output logic  wdt_tick
);

    logic [3:0] alu_op;
    logic [7:0] result_q, result_d;
    logic       carry_q, carry_d;
    logic [8:0] sum;

    // opcode decode; only LOAD and STORE raise a memory request
    always_comb begin
        alu_op        = ALU_NOP;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        unique case (bus.cu_op)
            OPC_OPIMM: alu_op = alu_from_funct(bus.funct3, bus.funct7_5, 1'b0);
            OPC_OP:    alu_op = alu_from_funct(bus.funct3, bus.funct7_5, 1'b1);
            OPC_LOAD: begin
                alu_op       = ALU_ADD;
                bus.mem_read = 1'b1;
            end
            OPC_STORE: begin
                alu_op        = ALU_ADD;
                bus.mem_write = 1'b1;
            end
            OPC_LUI:   alu_op = ALU_PASS_B;
            default:   alu_op = ALU_NOP;
        endcase
    end

    assign bus.alu_op = alu_op;
    assign sum = {1'b0, bus.A} + {1'b0, bus.B};

    // ALU next state; unlisted codes keep the previous result and carry
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        case (alu_op)
            ALU_ADD: begin
                result_d = sum[7:0];
                carry_d  = sum[8];
            end
            ALU_SUB: begin
                result_d = bus.A - bus.B;
                carry_d  = (bus.A >= bus.B);
            end
            ALU_AND: begin
                result_d = bus.A & bus.B;
                carry_d  = 1'b0;
            end
            ALU_OR: begin
                result_d = bus.A | bus.B;
                carry_d  = 1'b0;
            end
            ALU_XOR: begin
                result_d = bus.A ^ bus.B;
                carry_d  = 1'b0;
            end
`ifdef ALU_SHIFT_EN
            ALU_SLL: begin
                result_d = bus.A << bus.B[2:0];
                carry_d  = 1'b0;
            end
            ALU_SRL: begin
                result_d = bus.A >> bus.B[2:0];
                carry_d  = 1'b0;
            end
            ALU_SRA: begin
                result_d = 8'($signed(bus.A) >>> bus.B[2:0]);
                carry_d  = 1'b0;
            end
`endif
            ALU_SLT: begin
                result_d = {7'b0, ($signed(bus.A) < $signed(bus.B))};
                carry_d  = 1'b0;
            end
            ALU_SLTU: begin
                result_d = {7'b0, (bus.A < bus.B)};
                carry_d  = 1'b0;
            end
            ALU_PASS_B: begin
                result_d = bus.B;
                carry_d  = 1'b0;
            end
            default: begin
                result_d = result_q;
                carry_d  = carry_q;
            end
        endcase
    end

    // ALU output register, advances only on enabled cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else if (clk_enable) begin
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;

    exec_tickgen #(
        .LSI_DIV(LSI_DIV),
        .WDT_DIV(WDT_DIV)
    ) u_tickgen (
        .clk       (clk),
        .reset     (reset),
        .en_i      (clk_enable),
        .lsi_en_i  (lsi_enable),
        .lsi_tick_o(lsi_tick),
        .wdt_tick_o(wdt_tick)
    );

endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: directed scenarios plus random instructions against a
// behavioural model of decode, ALU arithmetic and tick periods.
module tb_exec_core;

    localparam int LSI_DIV = 4;
    localparam int WDT_DIV = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clk_enable = 1'b0;
    logic lsi_enable = 1'b0;
    logic lsi_tick;
    logic wdt_tick;

    exec_if bus();

    exec_core #(
        .LSI_DIV(LSI_DIV),
        .WDT_DIV(WDT_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_enable(clk_enable),
        .lsi_enable(lsi_enable),
        .bus       (bus),
        .lsi_tick  (lsi_tick),
        .wdt_tick  (wdt_tick)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] m_res;
    logic       m_cy;
    int         m_lsi;
    int         m_wdt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [6:0] opc,
                                          input logic [2:0] f3,
                                          input logic f7);
        logic [3:0] r;
        r = 4'hF;
        if (opc == 7'b0010011 || opc == 7'b0110011) begin
            case (f3)
                3'd0: r = (opc == 7'b0110011 && f7) ? 4'h1 : 4'h0;
                3'd1: r = 4'h5;
                3'd2: r = 4'h8;
                3'd3: r = 4'h9;
                3'd4: r = 4'h4;
                3'd5: r = f7 ? 4'h7 : 4'h6;
                3'd6: r = 4'h3;
                default: r = 4'h2;
            endcase
        end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
            r = 4'h0;
        end else if (opc == 7'b0110111) begin
            r = 4'hA;
        end
        return r;
    endfunction

    task automatic apply_alu(input logic [3:0] op, input logic [7:0] a,
                             input logic [7:0] b);
        int ia, ib, sa, sb, sh, s;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        sh = ib % 8;
        case (op)
            4'h0: begin
                s = ia + ib;
                m_res = 8'(s % 256);
                m_cy = (s > 255);
            end
            4'h1: begin
                m_res = 8'((ia - ib + 256) % 256);
                m_cy = (ia >= ib);
            end
            4'h2: begin m_res = a & b; m_cy = 1'b0; end
            4'h3: begin m_res = a | b; m_cy = 1'b0; end
            4'h4: begin m_res = a ^ b; m_cy = 1'b0; end
`ifdef ALU_SHIFT_EN
            4'h5: begin m_res = 8'((ia * (1 << sh)) % 256); m_cy = 1'b0; end
            4'h6: begin m_res = 8'(ia / (1 << sh)); m_cy = 1'b0; end
            4'h7: begin m_res = 8'((sa >>> sh) & 255); m_cy = 1'b0; end
`endif
            4'h8: begin m_res = (sa < sb) ? 8'd1 : 8'd0; m_cy = 1'b0; end
            4'h9: begin m_res = (ia < ib) ? 8'd1 : 8'd0; m_cy = 1'b0; end
            4'hA: begin m_res = b; m_cy = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_res = 8'h00;
        m_cy = 1'b0;
        m_lsi = 0;
        m_wdt = 0;
    endtask

    // one clock cycle: check decode/ticks mid-cycle, then registers after edge
    task automatic do_cycle(output logic got_lsi, output logic got_wdt);
        logic [3:0] eop;
        logic elsi, ewdt;
        #1;
        eop = ref_op(bus.cu_op, bus.funct3, bus.funct7_5);
        chk("alu_op", bus.alu_op, eop);
        chk("mem_read", bus.mem_read, bus.cu_op == 7'b0000011);
        chk("mem_write", bus.mem_write, bus.cu_op == 7'b0100011);
        elsi = reset && clk_enable && lsi_enable &&
               (((m_lsi + 1) % LSI_DIV) == 0);
        ewdt = elsi && (((m_wdt + 1) % WDT_DIV) == 0);
        got_lsi = lsi_tick;
        got_wdt = wdt_tick;
        chk("lsi_tick", lsi_tick, elsi);
        chk("wdt_tick", wdt_tick, ewdt);
        @(posedge clk);
        if (reset && clk_enable) begin
            apply_alu(eop, bus.A, bus.B);
            if (!lsi_enable) m_lsi = 0;
            else m_lsi++;
            if (elsi) m_wdt++;
        end
        #1;
        chk("result", bus.result, m_res);
        chk("carry", bus.carry_out, m_cy);
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3,
                         input logic f7, input logic [7:0] a,
                         input logic [7:0] b);
        bus.cu_op = opc;
        bus.funct3 = f3;
        bus.funct7_5 = f7;
        bus.A = a;
        bus.B = b;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic gl, gw;
        logic [6:0] opc;
        int k;
        int r;
        model_reset();
        drive(7'b0110111, 3'd0, 1'b0, 8'h00, 8'h00);
        #3;
        chk("rst_result", bus.result, 8'h00);
        chk("rst_carry", bus.carry_out, 1'b0);
        chk("rst_lsi", lsi_tick, 1'b0);
        chk("rst_wdt", wdt_tick, 1'b0);
        chk("rst_dec", bus.alu_op, 4'hA);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clk_enable = 1'b1;
        lsi_enable = 1'b1;

        // tick periods from reset release
        drive(7'b1111111, 3'd0, 1'b0, 8'h00, 8'h00);
        for (int c = 1; c <= 16; c++) begin
            do_cycle(gl, gw);
            chk("t5_lsi", gl, (c % 4) == 0);
            chk("t5_wdt", gw, (c % 8) == 0);
        end
        clk_enable = 1'b0;
        drive(7'b0010011, 3'd0, 1'b0, 8'h33, 8'h44);
        for (int c = 1; c <= 5; c++) begin
            do_cycle(gl, gw);
            chk("t5_frz_lsi", gl, 1'b0);
            chk("t5_frz_res", bus.result, 8'h00);
        end
        clk_enable = 1'b1;
        drive(7'b1111111, 3'd0, 1'b0, 8'h00, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            do_cycle(gl, gw);
            chk("t5_resume", gl, c == 4);
        end

        // directed ALU cases
        drive(7'b0010011, 3'd0, 1'b0, 8'h10, 8'h0A);
        do_cycle(gl, gw);
        chk("t1_res", bus.result, 8'h1A);
        chk("t1_cy", bus.carry_out, 1'b0);
        drive(7'b0110011, 3'd0, 1'b1, 8'h05, 8'h07);
        do_cycle(gl, gw);
        chk("t2a_res", bus.result, 8'hFE);
        chk("t2a_cy", bus.carry_out, 1'b0);
        drive(7'b0110011, 3'd0, 1'b1, 8'h07, 8'h05);
        do_cycle(gl, gw);
        chk("t2b_res", bus.result, 8'h02);
        chk("t2b_cy", bus.carry_out, 1'b1);
        drive(7'b0000011, 3'd2, 1'b1, 8'hF0, 8'h20);
        do_cycle(gl, gw);
        chk("t3_rd", bus.mem_read, 1'b1);
        chk("t3_res", bus.result, 8'h10);
        chk("t3_cy", bus.carry_out, 1'b1);
        drive(7'b0100011, 3'd0, 1'b0, 8'hF0, 8'h20);
        do_cycle(gl, gw);
        chk("t3_wr", bus.mem_write, 1'b1);
        drive(7'b1111111, 3'd0, 1'b0, 8'h55, 8'h66);
        do_cycle(gl, gw);
        chk("t3_nop_op", bus.alu_op, 4'hF);
        chk("t3_nop_res", bus.result, 8'h10);
        drive(7'b0010011, 3'd5, 1'b1, 8'h80, 8'h03);
        do_cycle(gl, gw);
`ifdef ALU_SHIFT_EN
        chk("t4_sra", bus.result, 8'hF0);
`else
        chk("t4_hold", bus.result, 8'h10);
`endif

        // random instruction stream
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 5));
            case (r)
                0: opc = 7'b0010011;
                1: opc = 7'b0110011;
                2: opc = 7'b0000011;
                3: opc = 7'b0100011;
                4: opc = 7'b0110111;
                default: opc = 7'($urandom);
            endcase
            drive(opc, 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            clk_enable = ($urandom_range(0, 9) != 0);
            lsi_enable = ($urandom_range(0, 19) != 0);
            do_cycle(gl, gw);
        end

        // async reset in the middle of a count
        clk_enable = 1'b1;
        lsi_enable = 1'b1;
        drive(7'b0010011, 3'd0, 1'b0, 8'h10, 8'h0A);
        do_cycle(gl, gw);
        drive(7'b1111111, 3'd0, 1'b0, 8'h00, 8'h00);
        k = 0;
        while ((((m_lsi + 1) % LSI_DIV) != 0) && k < 10) begin
            do_cycle(gl, gw);
            k++;
        end
        chk("t6_pre_res", bus.result, 8'h1A);
        chk("t6_pre_lsi", lsi_tick, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        chk("t6_res", bus.result, 8'h00);
        chk("t6_cy", bus.carry_out, 1'b0);
        chk("t6_lsi", lsi_tick, 1'b0);
        chk("t6_wdt", wdt_tick, 1'b0);
        #1;
        reset = 1'b1;
        k = 0;
        gl = 1'b0;
        while (!gl && k < 20) begin
            do_cycle(gl, gw);
            k++;
        end
        chk("t6_first_tick", k, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
